mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller sitting between the byte-wide RAM/IO port and the two memory clients: instruction cache (miss refills) and load/store buffer (LSB).
- Responder end of the icache miss protocol: accepts a 32-bit fetch address with a request flag and returns the assembled little-endian word with a one-cycle valid pulse.
- Serialises all accesses into 1-byte RAM transactions and arbitrates between the two clients.

Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region, where stores stall on io_buffer_full.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global ready; when low, all state freezes
- rollback  input  1  pipeline flush; aborts speculative reads
- mem_din  input  8  RAM read data, valid the cycle after the address is sampled
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write, 0 = read
- io_buffer_full  input  1  IO write buffer full
- IC_addr  input  32  icache miss address
- IC_addr_sgn  input  1  icache miss request; level, held until serviced
- IC_val  output  32  fetched instruction word
- IC_val_sgn  output  1  one-cycle pulse; IC_val valid
- LSB_addr  input  32  load/store byte address
- LSB_sgn  input  1  LSB request; level, held until LSB_done
- LSB_wr  input  1  1 = store, 0 = load
- LSB_len  input  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
- LSB_wdata  input  32  store data, low bytes used
- LSB_rdata  output  32  load data, zero-extended
- LSB_done  output  1  one-cycle pulse; load data valid or store complete

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, internal buffers 0.
- When rdy is low: registers hold, except that mem_wr is forced to 0.
- States: IDLE, IFETCH, LOAD, STORE. All outputs are registered.
- IDLE arbitration, on an edge with a request:
  - LSB_sgn has priority over IC_addr_sgn. Store → STORE, load → LOAD, else icache request → IFETCH.
  - Latch the address, length (IFETCH = 4 bytes) and write data.
  - Drive mem_a = base address. mem_wr = 1 only for STORE (mem_dout = byte 0).
- IFETCH/LOAD, with request sampled at edge t:
  - Addresses base+0..base+n-1 are presented in consecutive cycles starting at t.
  - Byte k is captured at edge t+k+2 into bits [8k+7:8k].
  - On the edge capturing the last byte: pulse IC_val_sgn or LSB_done with the data, and return to IDLE.
  - 4-byte fetch latency: IC_val_sgn is high in the cycle after edge t+5.
  - A new request is not accepted on the completion edge; the next acceptance is one edge later.
- STORE:
  - Byte k is driven with mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1 in cycle t+k.
  - LSB_done pulses at edge t+n; mem_wr = 0 from then on.
- IO stall:
  - In STORE, when addr[17:16] == IO_ADDR_HI and io_buffer_full = 1, the current byte is not issued: mem_wr = 0 and the counter holds.
  - Resume when io_buffer_full drops.
- Rollback (sampled when rdy = 1):
  - IFETCH or LOAD in progress: abort, go to IDLE, suppress any pulse in that cycle, mem_wr = 0.
  - STORE is never aborted, because stores are committed.
  - Rollback in IDLE: no effect; the request is not accepted that edge.
- Idle outputs: mem_wr = 0 whenever not actively writing a byte. In IDLE, mem_a holds its last value.
- Reset mid-operation: immediate return to IDLE, no pulse, mem_wr = 0.
- Addresses wrap modulo 2^32.
- IC_val and LSB_rdata hold their values between pulses.

Test Plan:
- Icache refill: RAM[0x100..0x103] = 13,05,00,00; IC_addr_sgn = 1, IC_addr = 0x100 → mem_a 0x100..0x103 on successive cycles, IC_val = 0x00000513, one-cycle IC_val_sgn at 5-cycle latency.
- Contention: IC_addr_sgn and LSB load (len = 2, addr 0x200 with bytes AA,BB) raised together → LOAD first, LSB_rdata = 0x0000BBAA, then fetch serviced; no overlap on mem_a.
- Store word 0xDEADBEEF to 0x300 → mem_wr = 1 for 4 cycles, bytes EF,BE,AD,DE at 0x300..0x303, LSB_done after the 4th byte, mem_wr = 0 afterwards.
- IO stall: store 1 byte 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0, write issues the cycle after full drops, then LSB_done.
- Rollback during fetch after 2 bytes → no IC_val_sgn, IDLE next cycle. Rollback during a store → store completes normally.
- rdy low for 2 cycles mid-load → counter and mem_a frozen, mem_wr = 0, correct data once resumed. rst asserted mid-store → all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates icache refills and LSB loads/stores
// onto a single 8-bit RAM/IO port, assembling little-endian words on reads.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic [31:0] IC_addr,
  input  logic        IC_addr_sgn,
  output logic [31:0] IC_val,
  output logic        IC_val_sgn,
  input  logic [31:0] LSB_addr,
  input  logic        LSB_sgn,
  input  logic        LSB_wr,
  input  logic [1:0]  LSB_len,
  input  logic [31:0] LSB_wdata,
  output logic [31:0] LSB_rdata,
  output logic        LSB_done
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] buf_q, buf_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_dout_q, mem_dout_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] ic_val_q, ic_val_d;
  logic          ic_sgn_q, ic_sgn_d;
  logic [AW-1:0] lsb_rdata_q, lsb_rdata_d;
  logic          lsb_done_q, lsb_done_d;

  logic [CW-1:0] nxt_idx;
  logic [1:0]    rd_byte;
  logic [4:0]    rd_sh;

  // Next-state and output logic; reads capture byte cnt-1, stores advance only
  // after a byte was actually presented with mem_wr high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    ic_val_d    = ic_val_q;
    ic_sgn_d    = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    lsb_done_d  = 1'b0;
    nxt_idx     = cnt_q;
    rd_byte     = cnt_q[1:0] - 2'd1;
    rd_sh       = {rd_byte, 3'b000};

    case (state_q)
      IDLE: begin
        if (!rollback && LSB_sgn) begin
          base_d  = LSB_addr;
          wdata_d = LSB_wdata;
          buf_d   = '0;
          cnt_d   = '0;
          mem_a_d = LSB_addr;
          case (LSB_len)
            2'd0:    len_d = CW'(1);
            2'd1:    len_d = CW'(2);
            default: len_d = CW'(4);
          endcase
          if (LSB_wr) begin
            state_d    = STORE;
            mem_dout_d = LSB_wdata[7:0];
            mem_wr_d   = !((LSB_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
          end else begin
            state_d = LOAD;
          end
        end else if (!rollback && IC_addr_sgn) begin
          state_d = IFETCH;
          base_d  = IC_addr;
          len_d   = CW'(4);
          buf_d   = '0;
          cnt_d   = '0;
          mem_a_d = IC_addr;
        end
      end
      IFETCH, LOAD: begin
        if (rollback) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q != '0) buf_d = buf_q | (AW'(mem_din) << rd_sh);
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IFETCH) begin
              ic_val_d = buf_d;
              ic_sgn_d = 1'b1;
            end else begin
              lsb_rdata_d = buf_d;
              lsb_done_d  = 1'b1;
            end
          end else if ((cnt_q + CW'(1)) < len_q) begin
            mem_a_d = base_q + AW'(cnt_q + CW'(1));
          end
        end
      end
      STORE: begin
        if (mem_wr_q && ((cnt_q + CW'(1)) == len_q)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lsb_done_d = 1'b1;
        end else begin
          nxt_idx    = mem_wr_q ? cnt_q + CW'(1) : cnt_q;
          cnt_d      = nxt_idx;
          mem_a_d    = base_q + AW'(nxt_idx);
          mem_dout_d = DW'(wdata_q >> {nxt_idx[1:0], 3'b000});
          mem_wr_d   = !((mem_a_d[17:16] == IO_ADDR_HI) && io_buffer_full);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; a frozen cycle still drops mem_wr so nothing is written twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_val_q    <= '0;
      ic_sgn_q    <= 1'b0;
      lsb_rdata_q <= '0;
      lsb_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_val_q    <= ic_val_d;
      ic_sgn_q    <= ic_sgn_d;
      lsb_rdata_q <= lsb_rdata_d;
      lsb_done_q  <= lsb_done_d;
    end else begin
      mem_wr_q <= 1'b0;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign IC_val     = ic_val_q;
  assign IC_val_sgn = ic_sgn_q;
  assign LSB_rdata  = lsb_rdata_q;
  assign LSB_done   = lsb_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model frozen with rdy, golden byte array as reference,
// directed scenarios plus randomized back-to-back traffic.
module tb_mem_ctrl;

  localparam int RAM_SZ = 1 << 18;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic [31:0] IC_addr = '0;
  logic        IC_addr_sgn = 1'b0;
  logic [31:0] IC_val;
  logic        IC_val_sgn;
  logic [31:0] LSB_addr = '0;
  logic        LSB_sgn = 1'b0, LSB_wr = 1'b0;
  logic [1:0]  LSB_len = '0;
  logic [31:0] LSB_wdata = '0;
  logic [31:0] LSB_rdata;
  logic        LSB_done;

  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
  wr_t         wlog[$];
  logic [7:0]  ram  [RAM_SZ];
  logic [7:0]  gold [RAM_SZ];
  logic [31:0] trace [64];
  int vectors = 0, miscompares = 0;

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn), .IC_val(IC_val), .IC_val_sgn(IC_val_sgn),
    .LSB_addr(LSB_addr), .LSB_sgn(LSB_sgn), .LSB_wr(LSB_wr), .LSB_len(LSB_len),
    .LSB_wdata(LSB_wdata), .LSB_rdata(LSB_rdata), .LSB_done(LSB_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // RAM: samples address on active edges only; read data valid the following cycle.
  task automatic ram_proc();
    logic [7:0] rd;
    forever begin
      @(posedge clk);
      if (rdy) begin
        rd = ram[mem_a[17:0]];
        if (mem_wr) begin
          ram[mem_a[17:0]] = mem_dout;
          wlog.push_back({mem_a, mem_dout});
        end
        mem_din <= rd;
      end
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = gold[18'(a + 32'(k))];
    return w;
  endfunction

  task automatic gold_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) gold[18'(a + 32'(k))] = wd[8*k +: 8];
  endtask

  function automatic bit log_matches(input logic [31:0] a, input int n, input logic [31:0] wd);
    if (wlog.size() != n) return 1'b0;
    for (int k = 0; k < n; k++)
      if (wlog[k] !== {a + 32'(k), wd[8*k +: 8]}) return 1'b0;
    return 1'b1;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a[17:0]] = b;
    gold[a[17:0]] = b;
  endtask

  // kind: 0 = fetch, 1 = load, 2 = store. Starts and ends just after a negedge.
  task automatic run_req(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd, output int lat, output logic [31:0] data,
                         output bit tmo);
    lat = 0; tmo = 1'b1; data = '0;
    if (kind == 0) begin
      IC_addr = addr; IC_addr_sgn = 1'b1;
    end else begin
      LSB_addr = addr; LSB_len = len; LSB_wr = (kind == 2); LSB_wdata = wd; LSB_sgn = 1'b1;
    end
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      trace[lat] = mem_a;
      if ((kind == 0) ? IC_val_sgn : LSB_done) begin
        data = (kind == 0) ? IC_val : LSB_rdata;
        tmo = 1'b0;
        break;
      end
    end
    IC_addr_sgn = 1'b0;
    LSB_sgn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_a, mem_dout, mem_wr, IC_val, IC_val_sgn, LSB_rdata, LSB_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b icv=%h icp=%b rd=%h done=%b, want all 0",
               mem_a, mem_dout, mem_wr, IC_val, IC_val_sgn, LSB_rdata, LSB_done);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_wr, IC_val_sgn, LSB_done, mem_a} !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: wr=%b icp=%b done=%b mem_a=%h, want 0", mem_wr, IC_val_sgn, LSB_done, mem_a);
    end
  endtask

  task automatic test_ifetch();
    int lat; logic [31:0] d; bit tmo;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    run_req(0, 32'h100, 2'd2, '0, lat, d, tmo);
    vectors++;
    if (tmo !== 1'b0 || lat !== 6) begin
      miscompares++; $display("FAIL ifetch_latency: tmo=%b negedges=%0d, want 6", tmo, lat);
    end
    vectors++;
    if (d !== 32'h00000513) begin miscompares++; $display("FAIL ifetch_data: got %h want 00000513", d); end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (trace[i] !== 32'h100 + 32'(i - 1)) begin
        miscompares++; $display("FAIL ifetch_addr%0d: got %h want %h", i, trace[i], 32'h100 + 32'(i - 1));
      end
    end
    @(negedge clk);
    vectors++;
    if (IC_val_sgn !== 1'b0 || IC_val !== 32'h00000513 || mem_wr !== 1'b0) begin
      miscompares++; $display("FAIL ifetch_pulse_hold: sgn=%b val=%h wr=%b, want 0/00000513/0", IC_val_sgn, IC_val, mem_wr);
    end
  endtask

  task automatic test_contention();
    int n = 0, gap = 0; bit early = 1'b0, got = 1'b0;
    logic [31:0] a_after = '0;
    preload(32'h200, 8'hAA); preload(32'h201, 8'hBB);
    IC_addr = 32'h100; IC_addr_sgn = 1'b1;
    LSB_addr = 32'h200; LSB_len = 2'd1; LSB_wr = 1'b0; LSB_sgn = 1'b1;
    while (n < 40 && !got) begin
      @(negedge clk); n++;
      trace[n] = mem_a;
      if (IC_val_sgn) early = 1'b1;
      if (LSB_done) got = 1'b1;
    end
    LSB_sgn = 1'b0;
    vectors++;
    if (!got || n !== 4 || early) begin
      miscompares++; $display("FAIL contention_load: done=%b negedges=%0d fetch_first=%b, want 1/4/0", got, n, early);
    end
    vectors++;
    if (LSB_rdata !== 32'h0000BBAA || trace[1] !== 32'h200 || trace[2] !== 32'h201) begin
      miscompares++; $display("FAIL contention_rdata: rdata=%h a1=%h a2=%h, want 0000BBAA/200/201", LSB_rdata, trace[1], trace[2]);
    end
    got = 1'b0;
    while (gap < 40 && !got) begin
      @(negedge clk); gap++;
      if (gap == 1) a_after = mem_a;
      if (IC_val_sgn) got = 1'b1;
    end
    IC_addr_sgn = 1'b0;
    vectors++;
    if (!got || gap !== 6 || a_after !== 32'h100 || IC_val !== gold_word(32'h100, 4)) begin
      miscompares++; $display("FAIL contention_fetch: got=%b gap=%0d first_a=%h val=%h, want 1/6/100/%h",
                              got, gap, a_after, IC_val, gold_word(32'h100, 4));
    end
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] d; bit tmo;
    wlog.delete();
    run_req(2, 32'h300, 2'd2, 32'hDEADBEEF, lat, d, tmo);
    gold_store(32'h300, 4, 32'hDEADBEEF);
    vectors++;
    if (tmo !== 1'b0 || lat !== 5) begin miscompares++; $display("FAIL store_latency: tmo=%b negedges=%0d, want 5", tmo, lat); end
    vectors++;
    if (log_matches(32'h300, 4, 32'hDEADBEEF) !== 1'b1) begin
      miscompares++; $display("FAIL store_bytes: %0d writes logged, want EF,BE,AD,DE at 300..303", wlog.size());
    end
    vectors++;
    if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL store_wr_after: mem_wr=%b want 0", mem_wr); end
    run_req(1, 32'h300, 2'd2, '0, lat, d, tmo);
    vectors++;
    if (tmo !== 1'b0 || d !== 32'hDEADBEEF || lat !== 6) begin
      miscompares++; $display("FAIL store_readback: data=%h lat=%0d, want DEADBEEF/6", d, lat);
    end
  endtask

  task automatic test_io_stall();
    wlog.delete();
    io_buffer_full = 1'b1;
    LSB_addr = 32'h30000; LSB_len = 2'd0; LSB_wr = 1'b1; LSB_wdata = 32'h41; LSB_sgn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_wr !== 1'b0 || LSB_done !== 1'b0) begin
        miscompares++; $display("FAIL io_stall_hold%0d: wr=%b done=%b, want 0/0", i, mem_wr, LSB_done);
      end
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
      miscompares++; $display("FAIL io_stall_issue: wr=%b a=%h dout=%h, want 1/30000/41", mem_wr, mem_a, mem_dout);
    end
    @(negedge clk);
    LSB_sgn = 1'b0;
    gold_store(32'h30000, 1, 32'h41);
    vectors++;
    if (LSB_done !== 1'b1 || mem_wr !== 1'b0 || log_matches(32'h30000, 1, 32'h41) !== 1'b1) begin
      miscompares++; $display("FAIL io_stall_done: done=%b wr=%b writes=%0d, want 1/0/1", LSB_done, mem_wr, wlog.size());
    end
  endtask

  task automatic test_rollback();
    int lat = 0; logic [31:0] d; bit tmo, seen = 1'b0, got = 1'b0;
    logic [31:0] prev = IC_val;
    IC_addr = 32'h400; IC_addr_sgn = 1'b1;
    repeat (4) begin @(negedge clk); if (IC_val_sgn) seen = 1'b1; end
    rollback = 1'b1; IC_addr_sgn = 1'b0;
    @(negedge clk);
    rollback = 1'b0;
    if (IC_val_sgn) seen = 1'b1;
    @(negedge clk);
    if (IC_val_sgn) seen = 1'b1;
    vectors++;
    if (seen || IC_val !== prev || mem_wr !== 1'b0) begin
      miscompares++; $display("FAIL rollback_fetch: pulse=%b val=%h wr=%b, want 0/%h/0", seen, IC_val, mem_wr, prev);
    end
    run_req(1, 32'h208, 2'd0, '0, lat, d, tmo);
    vectors++;
    if (tmo !== 1'b0 || lat !== 3 || d !== {24'h0, gold[18'h208]}) begin
      miscompares++; $display("FAIL rollback_idle_next: lat=%0d data=%h, want 3/%h", lat, d, {24'h0, gold[18'h208]});
    end
    // Rollback in IDLE blocks acceptance for that edge only.
    LSB_addr = 32'h210; LSB_len = 2'd0; LSB_wr = 1'b0; LSB_sgn = 1'b1; rollback = 1'b1;
    lat = 0;
    while (lat < 40 && !got) begin
      @(negedge clk); lat++; rollback = 1'b0;
      if (LSB_done) got = 1'b1;
    end
    LSB_sgn = 1'b0;
    vectors++;
    if (!got || lat !== 4 || LSB_rdata !== {24'h0, gold[18'h210]}) begin
      miscompares++; $display("FAIL rollback_in_idle: lat=%0d data=%h, want 4/%h", lat, LSB_rdata, {24'h0, gold[18'h210]});
    end
    // Stores are committed and ignore rollback.
    wlog.delete();
    LSB_addr = 32'h500; LSB_len = 2'd2; LSB_wr = 1'b1; LSB_wdata = 32'h0BADF00D; LSB_sgn = 1'b1;
    lat = 0; got = 1'b0;
    while (lat < 40 && !got) begin
      @(negedge clk); lat++;
      rollback = (lat == 1 || lat == 2);
      if (LSB_done) got = 1'b1;
    end
    LSB_sgn = 1'b0; rollback = 1'b0;
    gold_store(32'h500, 4, 32'h0BADF00D);
    vectors++;
    if (!got || lat !== 5 || log_matches(32'h500, 4, 32'h0BADF00D) !== 1'b1) begin
      miscompares++; $display("FAIL rollback_store: done=%b lat=%0d writes=%0d, want 1/5/4", got, lat, wlog.size());
    end
  endtask

  task automatic test_rdy_freeze();
    int lat = 2; bit got = 1'b0;
    LSB_addr = 32'h600; LSB_len = 2'd2; LSB_wr = 1'b0; LSB_sgn = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); lat++;
      vectors++;
      if (mem_a !== 32'h601 || mem_wr !== 1'b0 || LSB_done !== 1'b0) begin
        miscompares++; $display("FAIL freeze_load%0d: a=%h wr=%b done=%b, want 601/0/0", i, mem_a, mem_wr, LSB_done);
      end
    end
    rdy = 1'b1;
    while (lat < 40 && !got) begin @(negedge clk); lat++; if (LSB_done) got = 1'b1; end
    LSB_sgn = 1'b0;
    vectors++;
    if (!got || lat !== 8 || LSB_rdata !== gold_word(32'h600, 4)) begin
      miscompares++; $display("FAIL freeze_load_data: lat=%0d data=%h, want 8/%h", lat, LSB_rdata, gold_word(32'h600, 4));
    end
    wlog.delete();
    LSB_addr = 32'h700; LSB_len = 2'd2; LSB_wr = 1'b1; LSB_wdata = 32'h13572468; LSB_sgn = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL freeze_store_wr: mem_wr=%b want 0", mem_wr); end
    rdy = 1'b1; lat = 3; got = 1'b0;
    while (lat < 40 && !got) begin @(negedge clk); lat++; if (LSB_done) got = 1'b1; end
    LSB_sgn = 1'b0;
    gold_store(32'h700, 4, 32'h13572468);
    vectors++;
    if (!got || lat !== 7 || log_matches(32'h700, 4, 32'h13572468) !== 1'b1) begin
      miscompares++; $display("FAIL freeze_store: lat=%0d writes=%0d, want 7/4", lat, wlog.size());
    end
  endtask

  task automatic test_reset_mid_store();
    wlog.delete();
    LSB_addr = 32'h800; LSB_len = 2'd2; LSB_wr = 1'b1; LSB_wdata = 32'hA1B2C3D4; LSB_sgn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; LSB_sgn = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_a, mem_dout, mem_wr, IC_val, IC_val_sgn, LSB_rdata, LSB_done} !== '0) begin
      miscompares++; $display("FAIL reset_mid_store: a=%h dout=%h wr=%b icv=%h rd=%h done=%b, want all 0",
                              mem_a, mem_dout, mem_wr, IC_val, LSB_rdata, LSB_done);
    end
    rst = 1'b0;
    gold_store(32'h800, 2, 32'hA1B2C3D4);
    vectors++;
    if (log_matches(32'h800, 2, 32'hA1B2C3D4) !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_store_bytes: %0d writes, want 2 (D4,C3)", wlog.size());
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d; bit tmo;
    run_req(0, 32'hFFFFFFFE, 2'd2, '0, lat, d, tmo);
    vectors++;
    if (tmo !== 1'b0 || lat !== 6 || d !== gold_word(32'hFFFFFFFE, 4) || trace[3] !== 32'h0 || trace[4] !== 32'h1) begin
      miscompares++; $display("FAIL wrap_fetch: lat=%0d data=%h a3=%h a4=%h, want 6/%h/0/1",
                              lat, d, trace[3], trace[4], gold_word(32'hFFFFFFFE, 4));
    end
  endtask

  task automatic test_back_to_back();
    int lat, kind, n; logic [31:0] d, a, wd; logic [1:0] len; bit tmo;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 32'h2FFF0));
      len = (kind == 0) ? 2'd2 : 2'($urandom_range(0, 2));
      n = nbytes(len);
      wd = $urandom;
      wlog.delete();
      run_req(kind, a, len, wd, lat, d, tmo);
      vectors++;
      if (tmo !== 1'b0 || lat !== ((kind == 2) ? n + 1 : n + 2)) begin
        miscompares++; $display("FAIL rand%0d_latency: kind=%0d len=%0d lat=%0d tmo=%b", i, kind, n, lat, tmo);
      end
      vectors++;
      if (kind == 2) begin
        gold_store(a, n, wd);
        if (log_matches(a, n, wd) !== 1'b1) begin
          miscompares++; $display("FAIL rand%0d_store: addr=%h n=%0d wd=%h writes=%0d", i, a, n, wd, wlog.size());
        end
      end else if (d !== gold_word(a, n)) begin
        miscompares++; $display("FAIL rand%0d_read: kind=%0d addr=%h got %h want %h", i, kind, a, d, gold_word(a, n));
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < RAM_SZ; i++) begin b = 8'($urandom); ram[i] = b; gold[i] = b; end
    fork ram_proc(); join_none
    @(negedge clk);
    test_reset();
    test_ifetch();
    test_contention();
    test_store_word();
    test_io_stall();
    test_rollback();
    test_rdy_freeze();
    test_reset_mid_store();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
